// File: rtl/stream_demux_spill.sv
// Registered 1-to-N stream demultiplexer with a two-entry spill buffer.
// Slot A is the head driving all outputs; slot B absorbs one beat of backpressure.
module stream_demux_spill #(
  parameter int DATA_WIDTH = 32,
  parameter int N_OUP      = 2,
  parameter int LOG_N_OUP  = (N_OUP > 1) ? $clog2(N_OUP) : 1
) (
  input  logic                  clk_i,
  input  logic                  rst_ni,
  input  logic                  flush_i,
  input  logic [DATA_WIDTH-1:0] inp_data_i,
  input  logic [LOG_N_OUP-1:0]  inp_sel_i,
  input  logic                  inp_valid_i,
  output logic                  inp_ready_o,
  output logic [DATA_WIDTH-1:0] oup_data_o,
  output logic [N_OUP-1:0]      oup_valid_o,
  input  logic [N_OUP-1:0]      oup_ready_i
);

  logic [DATA_WIDTH-1:0] a_data, b_data;
  logic [LOG_N_OUP-1:0]  a_sel, b_sel;
  logic                  a_full, b_full;

  logic                  in_fire;
  logic                  sel_ok;
  logic                  in_keep;
  logic [LOG_N_OUP-1:0]  in_sel;
  logic                  sel_rdy;
  logic                  out_fire;

  assign inp_ready_o = ~b_full;
  assign oup_data_o  = a_data;

  assign in_fire = inp_valid_i & inp_ready_o;
  assign sel_ok  = (N_OUP == 1) || (int'(inp_sel_i) < N_OUP);
  assign in_keep = in_fire & sel_ok;
  assign in_sel  = (N_OUP == 1) ? '0 : inp_sel_i;

  // Decode head select; ready bits of other outputs are ignored.
  always_comb begin
    oup_valid_o = '0;
    sel_rdy     = 1'b0;
    for (int k = 0; k < N_OUP; k++) begin
      if (a_sel == LOG_N_OUP'(k)) begin
        oup_valid_o[k] = a_full;
        sel_rdy        = oup_ready_i[k];
      end
    end
  end

  assign out_fire = a_full & sel_rdy;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      a_data <= '0;
      a_sel  <= '0;
      a_full <= 1'b0;
      b_data <= '0;
      b_sel  <= '0;
      b_full <= 1'b0;
    end else if (flush_i) begin
      a_full <= 1'b0;
      b_full <= 1'b0;
    end else if (!a_full) begin
      if (in_keep) begin
        a_full <= 1'b1;
        a_data <= inp_data_i;
        a_sel  <= in_sel;
      end
    end else if (out_fire) begin
      if (b_full) begin
        a_data <= b_data;
        a_sel  <= b_sel;
        b_full <= 1'b0;
      end else if (in_keep) begin
        a_data <= inp_data_i;
        a_sel  <= in_sel;
      end else begin
        a_full <= 1'b0;
      end
    end else if (in_keep) begin
      b_full <= 1'b1;
      b_data <= inp_data_i;
      b_sel  <= in_sel;
    end
  end

  if (N_OUP < 1) begin : g_bad_n_oup
    $error("stream_demux_spill: N_OUP must be >= 1");
  end

`ifndef SYNTHESIS
  a_inp_stable : assert property (
    @(posedge clk_i) disable iff (!rst_ni)
    (inp_valid_i && !inp_ready_o) |=>
      (!inp_valid_i || ($stable(inp_data_i) && $stable(inp_sel_i))))
    else $error("stream_demux_spill: input changed while stalled");

  a_sel_range : assert property (
    @(posedge clk_i) disable iff (!rst_ni)
    in_fire |-> sel_ok)
    else $warning("stream_demux_spill: out-of-range select dropped");
`endif

endmodule

// File: tb/tb_stream_demux_spill.sv
// Randomized bench for stream_demux_spill (N_OUP=4 and N_OUP=3 side by side)
// checked against a queue-based FIFO reference model.
module tb_stream_demux_spill;

  localparam int DW = 16;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          flush = 1'b0;
  logic [DW-1:0] in_data = '0;
  logic [1:0]    in_sel = '0;
  logic          in_valid = 1'b0;

  logic          rdy_o4, rdy_o3;
  logic [DW-1:0] data4, data3;
  logic [3:0]    val4;
  logic [2:0]    val3;
  logic [3:0]    ordy4 = '0;
  logic [2:0]    ordy3 = '0;

  int checks = 0;
  int failures = 0;

  typedef struct {
    logic [DW-1:0] d;
    logic [1:0]    s;
  } beat_t;

  beat_t q4[$];
  beat_t q3[$];
  bit    held = 0;

  always #5 clk = ~clk;

  stream_demux_spill #(.DATA_WIDTH(DW), .N_OUP(4)) u_dut4 (
    .clk_i(clk), .rst_ni(rst_n), .flush_i(flush),
    .inp_data_i(in_data), .inp_sel_i(in_sel),
    .inp_valid_i(in_valid), .inp_ready_o(rdy_o4),
    .oup_data_o(data4), .oup_valid_o(val4),
    .oup_ready_i(ordy4)
  );

  stream_demux_spill #(.DATA_WIDTH(DW), .N_OUP(3)) u_dut3 (
    .clk_i(clk), .rst_ni(rst_n), .flush_i(flush),
    .inp_data_i(in_data), .inp_sel_i(in_sel),
    .inp_valid_i(in_valid), .inp_ready_o(rdy_o3),
    .oup_data_o(data3), .oup_valid_o(val3),
    .oup_ready_i(ordy3)
  );

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h", tag, obs, exp);
    end
  endtask

  task automatic model_check();
    chk("rdy4", 32'(rdy_o4), 32'(q4.size() < 2));
    chk("rdy3", 32'(rdy_o3), 32'(q3.size() < 2));
    if (q4.size() > 0) begin
      chk("val4", 32'(val4), 32'(4'(1) << q4[0].s));
      chk("dat4", 32'(data4), 32'(q4[0].d));
    end else begin
      chk("val4_idle", 32'(val4), 32'd0);
    end
    if (q3.size() > 0) begin
      chk("val3", 32'(val3), 32'(3'(1) << q3[0].s));
      chk("dat3", 32'(data3), 32'(q3[0].d));
    end else begin
      chk("val3_idle", 32'(val3), 32'd0);
    end
  endtask

  // One cycle: drive, check model at negedge, advance model, land at edge+1.
  task automatic cyc(input logic v, input logic [DW-1:0] d,
                     input logic [1:0] s, input logic f,
                     input logic [3:0] r4, input logic [2:0] r3);
    bit    in4, in3, out4, out3;
    beat_t b;
    in_valid = v;
    in_data  = d;
    in_sel   = s;
    flush    = f;
    ordy4    = r4;
    ordy3    = r3;
    @(negedge clk);
    model_check();
    b.d  = d;
    b.s  = s;
    in4  = v && (q4.size() < 2);
    in3  = v && (q3.size() < 2);
    out4 = (q4.size() > 0) && r4[q4[0].s];
    out3 = (q3.size() > 0) && r3[q3[0].s];
    held = v && !(in4 && in3);
    if (f) begin
      q4.delete();
      q3.delete();
    end else begin
      if (out4) void'(q4.pop_front());
      if (out3) void'(q3.pop_front());
      if (in4) q4.push_back(b);
      if (in3 && s < 2'd3) q3.push_back(b);
    end
    @(posedge clk);
    #1;
  endtask

  initial begin
    logic          v, f;
    logic [DW-1:0] d;
    logic [1:0]    s;
    logic [3:0]    r4;

    // Reset state
    #12;
    chk("rst_rdy4", 32'(rdy_o4), 32'd1);
    chk("rst_val4", 32'(val4), 32'd0);
    chk("rst_dat4", 32'(data4), 32'd0);
    chk("rst_val3", 32'(val3), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    chk("idle_rdy4", 32'(rdy_o4), 32'd1);
    chk("idle_dat4", 32'(data4), 32'd0);

    // Back-to-back streaming
    cyc(1, 16'h11, 2'd2, 0, 4'hF, 3'h7);
    chk("st1_val", 32'(val4), 32'h4);
    chk("st1_dat", 32'(data4), 32'h11);
    cyc(1, 16'h22, 2'd0, 0, 4'hF, 3'h7);
    chk("st2_val", 32'(val4), 32'h1);
    chk("st2_dat", 32'(data4), 32'h22);
    chk("st2_rdy", 32'(rdy_o4), 32'd1);
    cyc(0, 16'h0, 2'd0, 0, 4'hF, 3'h7);

    // Backpressure fill and drain
    cyc(1, 16'hA0, 2'd1, 0, 4'h0, 3'h0);
    cyc(1, 16'hA1, 2'd3, 0, 4'h0, 3'h0);
    chk("bp_rdy", 32'(rdy_o4), 32'd0);
    chk("bp_val", 32'(val4), 32'h2);
    chk("bp_dat", 32'(data4), 32'hA0);
    cyc(0, 16'h0, 2'd0, 0, 4'h8, 3'h0);
    chk("bp_hold_val", 32'(val4), 32'h2);
    chk("bp_hold_dat", 32'(data4), 32'hA0);
    chk("bp_hold_rdy", 32'(rdy_o4), 32'd0);
    cyc(0, 16'h0, 2'd0, 0, 4'h2, 3'h2);
    chk("bp_drn_val", 32'(val4), 32'h8);
    chk("bp_drn_dat", 32'(data4), 32'hA1);
    chk("bp_drn_rdy", 32'(rdy_o4), 32'd1);
    cyc(0, 16'h0, 2'd0, 0, 4'hF, 3'h7);

    // Flush with both slots full and a beat presented
    cyc(1, 16'hB0, 2'd0, 0, 4'h0, 3'h0);
    cyc(1, 16'hB1, 2'd1, 0, 4'h0, 3'h0);
    chk("fl_full", 32'(rdy_o4), 32'd0);
    cyc(1, 16'hBB, 2'd2, 1, 4'h0, 3'h0);
    chk("fl_val4", 32'(val4), 32'd0);
    chk("fl_rdy4", 32'(rdy_o4), 32'd1);
    chk("fl_val3", 32'(val3), 32'd0);
    chk("fl_rdy3", 32'(rdy_o3), 32'd1);
    cyc(0, 16'h0, 2'd0, 0, 4'hF, 3'h7);
    chk("fl_empty", 32'(val4), 32'd0);

    // Out-of-range select on N_OUP=3
    cyc(1, 16'h55, 2'd3, 0, 4'hF, 3'h7);
    chk("oor_drop", 32'(val3), 32'd0);
    cyc(1, 16'h66, 2'd1, 0, 4'hF, 3'h7);
    chk("oor_val", 32'(val3), 32'h2);
    chk("oor_dat", 32'(data3), 32'h66);
    cyc(0, 16'h0, 2'd0, 0, 4'hF, 3'h7);

    // Async reset mid-transfer
    cyc(1, 16'hC0, 2'd0, 0, 4'h0, 3'h0);
    cyc(1, 16'hC1, 2'd1, 0, 4'h0, 3'h0);
    in_valid = 1'b0;
    #2;
    rst_n = 1'b0;
    #1;
    chk("ar_val4", 32'(val4), 32'd0);
    chk("ar_val3", 32'(val3), 32'd0);
    chk("ar_rdy4", 32'(rdy_o4), 32'd1);
    q4.delete();
    q3.delete();
    held = 0;
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    cyc(1, 16'hD0, 2'd1, 0, 4'hF, 3'h7);
    chk("ar_new_val", 32'(val4), 32'h2);
    chk("ar_new_dat", 32'(data4), 32'hD0);

    // Randomized traffic
    d = '0;
    s = '0;
    for (int i = 0; i < 3000; i++) begin
      if (!held) begin
        d = DW'($urandom);
        s = 2'($urandom);
      end
      v = ($urandom_range(0, 3) != 0);
      f = ($urandom_range(0, 49) == 0);
      r4 = '0;
      for (int k = 0; k < 4; k++) r4[k] = ($urandom_range(0, 9) < 7);
      cyc(v, d, s, f, r4, 3'($urandom));
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/stream_demux_spill.md
Name: stream_demux_spill

Overview:
- Registered 1-to-N stream demultiplexer: the counterpart of the selected-input stream mux.
- Accepts one valid/ready input stream carrying data plus a destination select, and routes each beat to exactly one of N_OUP output streams.
- A two-entry spill buffer cuts all combinational paths, valid, ready and data, between the input and output sides while sustaining one beat per cycle.
- Sits wherever a producer fans out to several consumers chosen per beat, e.g. steering requests to units or banks.

Parameters:
DATA_WIDTH, 32, width of the payload in bits.
N_OUP, 2, number of output streams; must be >= 1.
LOG_N_OUP, (N_OUP > 1) ? $clog2(N_OUP) : 1, derived select width; do not override.

Ports:
clk_i  input  1  clock; all state updates on the rising edge.
rst_ni  input  1  asynchronous active-low reset.
flush_i  input  1  synchronous clear of all buffered beats.
inp_data_i  input  DATA_WIDTH  input payload.
inp_sel_i  input  LOG_N_OUP  destination index, sampled with the payload.
inp_valid_i  input  1  input beat valid.
inp_ready_o  output  1  input beat accepted when both valid and ready are high.
oup_data_o  output  DATA_WIDTH  payload of the head beat, broadcast to all outputs.
oup_valid_o  output  N_OUP  one-hot-or-zero valid; bit k is high iff the head beat targets output k.
oup_ready_i  input  N_OUP  per-output ready.

Behaviour:
- State:
  - Slot A is the head and drives the outputs.
  - Slot B is the overflow slot.
  - Each slot holds {data, sel, full}.
- Reset (rst_ni low, async): both slots empty; data and sel cleared to 0.
  - Outputs during and after reset: oup_valid_o = 0, oup_data_o = 0, inp_ready_o = 1.
- Handshake signals:
  - inp_ready_o = ~B.full. It is a registered value with no combinational path from oup_ready_i.
  - oup_valid_o[k] = A.full & (A.sel == k). oup_data_o = A.data. Both come from registers only.
  - in_fire = inp_valid_i & inp_ready_o.
  - out_fire = A.full & oup_ready_i[A.sel]. The ready bits of non-selected outputs are ignored.
- Update rules, evaluated each cycle in this priority order:
  - flush_i = 1: A and B become empty; any in_fire beat that cycle is discarded; out_fire still counts as a completed transfer. After the edge, inp_ready_o = 1 and oup_valid_o = 0.
  - A empty: an in_fire beat loads A. B is empty by invariant.
  - A full, out_fire, B empty: A loads the in_fire beat if there is one, otherwise A becomes empty.
  - A full, out_fire, B full: B moves to A and B becomes empty. No in_fire is possible because ready = 0.
  - A full, no out_fire: an in_fire beat loads B.
- Invariants:
  - B full implies A full.
  - Ordering is strictly FIFO across all outputs; no reordering by destination.
- Latency and throughput:
  - A beat accepted at edge t is visible on oup_valid_o after edge t (1 cycle).
  - Throughput is 1 beat/cycle while the selected output stays ready.
  - Head-of-line blocking: a stalled destination blocks all beats behind it.
- Out-of-range select (N_OUP not a power of 2, inp_sel_i >= N_OUP): the beat is accepted and silently dropped, never stored. A simulation-only assertion flags it.
- Stability: while oup_valid_o[k] is high and oup_ready_i[k] is low, oup_data_o and oup_valid_o hold stable, unless flush_i is asserted.
- N_OUP = 1: behaves as a plain spill register; sel is ignored and treated as 0.
- Assertions (simulation only): N_OUP >= 1 at elaboration; inp_data_i and inp_sel_i stable while inp_valid_i is high and inp_ready_o is low.

Test Plan:
- Reset, then idle: after rst_ni deasserts, inp_ready_o = 1, oup_valid_o = 0, oup_data_o = 0.
- Streaming with N_OUP = 4: send 0x11 sel 2 and 0x22 sel 0 back-to-back, all readies high → oup_valid_o = 4'b0100 with data 0x11 one cycle after the first accept, then 4'b0001 with data 0x22 the next cycle; inp_ready_o stays 1.
- Backpressure fill: hold oup_ready_i = 0 and send 0xA0 sel 1, then 0xA1 sel 3 → both accepted, then inp_ready_o = 0. oup_valid_o = 4'b0010 holds with data 0xA0.
  - Raise oup_ready_i[3] only: no change.
  - Raise oup_ready_i[1]: 0xA0 drains, 0xA1 becomes head with oup_valid_o = 4'b1000, and inp_ready_o returns to 1 on the following cycle.
- Flush with both slots full and a beat presented on the input → next cycle oup_valid_o = 0, inp_ready_o = 1; neither buffered beat nor the presented beat ever appears.
- Out-of-range select with N_OUP = 3: send sel 3 with data 0x55, then sel 1 with data 0x66 → only 0x66 appears, on oup_valid_o = 3'b010.
- Async reset mid-transfer: assert rst_ni low between clock edges with both slots full → oup_valid_o = 0 immediately, without waiting for a clock edge; after release the block is empty and accepts new beats.
